frequency_generator: RTL and testbench
======================================

Name: frequency_generator

Overview:
Programmable square-wave source, the transmit-side counterpart of the frequency counter. It takes a two-digit BCD target (tens, units) and an update period in clocks. It then drives `signal` so that exactly N = 10*tens + units rising edges occur per update period. Used as an on-chip self-test stimulus and loopback source for the counter, sharing its period convention (default 1200 clocks).

Parameters:
UPDATE_PERIOD, 1200, reset value of the internal update period (clocks per measurement window)
BITS, 12, width of period input, period register and window arithmetic

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tens  input  4  BCD tens digit of target edge count
units  input  4  BCD units digit of target edge count
load  input  1  single-cycle strobe: capture tens/units and (re)start generation
period  input  BITS  new update period in clocks
period_load  input  1  single-cycle strobe: capture period
signal  output  1  generated square wave (registered)
busy  output  1  high while in CONVERT, CHECK or RUN
error  output  1  sticky: last load request rejected

Behaviour:
- Reset (async, immediate, no clock needed): signal=0, busy=0, error=0, state=IDLE, update_period=UPDATE_PERIOD, acc=0, n=0, tens_left=0.
- update_period register: loads `period` on any clk edge with period_load=1, in any state.
- period_load in RUN also clears acc to 0 on the same edge; the new period applies from the next cycle.
- States:
  - IDLE: signal=0, busy=0.
  - CONVERT, CHECK, RUN: busy=1.
- load accepted in any state. On the load edge:
  - If tens>9 or units>9: error<=1, signal<=0, go to IDLE.
  - Otherwise: error<=0, n<=units (7-bit), tens_left<=tens, acc<=0, signal<=0, go to CONVERT.
  - load has priority over all state actions on the same edge.
- CONVERT (repeated addition, one step per cycle):
  - If tens_left!=0: n<=n+10, tens_left<=tens_left-1.
  - Else go to CHECK.
  - Occupies tens+1 cycles.
- CHECK (1 cycle), with the current update_period:
  - If 2n > update_period: error<=1, go to IDLE.
  - Else go to RUN.
  - RUN is entered tens+2 clocks after the load edge.
- RUN (DDA / Bresenham), each cycle:
  - sum = acc + 2n, computed BITS+1 wide.
  - If sum >= update_period: acc<=sum-update_period and signal toggles.
  - Else acc<=sum.
  - Result: exactly 2n toggles (n rising edges) per update_period consecutive RUN cycles.
  - Each high/low level lasts floor(P/2n) or ceil(P/2n) clocks, minimum 1.
  - Any P-cycle window contains n or n±1 rising edges.
- n=0: RUN holds signal=0 indefinitely with no toggles; busy stays 1.
- 2n == update_period: signal toggles every cycle (period-2 square wave); this is legal.
- update_period=0: any n>0 fails CHECK. With n=0 in RUN, sum>=0 is always true, so signal toggles every cycle; this is accepted as degenerate configuration behaviour.
- period_load in RUN that makes 2n > new period: no re-check is made and generation continues with saturated behaviour (toggle every cycle). Software must reload to re-validate.
- Simultaneous load and period_load: both captured. The following CHECK uses the new period.

Test Plan:
1. Assert reset asynchronously mid-cycle -> signal, busy, error are 0 before the next clk edge. After release, update_period=1200.
2. load tens=4 units=2 -> busy=1 next cycle, RUN entered 6 clocks after the load edge. Exactly 84 toggles / 42 rising edges in the first 1200 RUN cycles. Every level width is 14 or 15 clocks.
3. period_load=100, then load tens=9 units=9 -> CHECK fails (198>100), error=1, busy=0, signal=0, 11 clocks after load. A following load tens=0 units=5 clears error and runs: 5 edges per 100 clocks.
4. load units=4'hA -> error=1 and IDLE on the next edge, no CONVERT cycles. Also load tens=0 units=0 -> RUN with signal constantly 0.
5. In RUN with n=42, period_load=600 -> acc cleared, then exactly 42 rising edges per 600 clocks. Also load n=17 mid-RUN -> signal forced 0 and generation restarts with 17 edges per period.
6. Loopback into frequency_counter, both with period 1200, load tens=3 units=7 -> each counter display update reads 37 or 38.

Source files
------------

// File: rtl/frequency_generator.sv
// Programmable square-wave source: n = 10*tens + units rising edges
// per update period, spread evenly with a DDA accumulator.
module frequency_generator #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int BITS          = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      tens,
  input  logic [3:0]      units,
  input  logic            load,
  input  logic [BITS-1:0] period,
  input  logic            period_load,
  output logic            signal,
  output logic            busy,
  output logic            error
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    CHECK,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] period_q, period_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [6:0]      n_q, n_d;
  logic [3:0]      tens_left_q, tens_left_d;
  logic            signal_q, signal_d;
  logic            busy_q, busy_d;
  logic            error_q, error_d;

  logic [BITS:0]   twice_n;
  logic [BITS:0]   period_x;
  logic [BITS:0]   sum;

  assign twice_n  = (BITS+1)'({n_q, 1'b0});
  assign period_x = {1'b0, period_q};
  assign sum      = {1'b0, acc_q} + twice_n;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    acc_d       = acc_q;
    n_d         = n_q;
    tens_left_d = tens_left_q;
    signal_d    = signal_q;
    error_d     = error_q;

    if (period_load) begin
      period_d = period;
    end

    if (load) begin
      signal_d = 1'b0;
      if (tens > 4'd9 || units > 4'd9) begin
        error_d = 1'b1;
        state_d = IDLE;
      end else begin
        error_d     = 1'b0;
        n_d         = {3'b000, units};
        tens_left_d = tens;
        acc_d       = '0;
        state_d     = CONVERT;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          signal_d = 1'b0;
        end
        CONVERT: begin
          if (tens_left_q != 4'd0) begin
            n_d         = n_q + 7'd10;
            tens_left_d = tens_left_q - 4'd1;
          end else begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (twice_n > period_x) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          // a new period restarts the accumulator instead of stepping
          if (period_load) begin
            acc_d = '0;
          end else if (sum >= period_x) begin
            acc_d    = BITS'(sum - period_x);
            signal_d = ~signal_q;
          end else begin
            acc_d = BITS'(sum);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      period_q    <= BITS'(UPDATE_PERIOD);
      acc_q       <= '0;
      n_q         <= '0;
      tens_left_q <= '0;
      signal_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      tens_left_q <= tens_left_d;
      signal_q    <= signal_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign signal = signal_q;
  assign busy   = busy_q;
  assign error  = error_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: closed-form edge-count reference model
// plus directed window and level-width checks, then random traffic.
module tb_frequency_generator;

  localparam int BITS = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      tens = '0;
  logic [3:0]      units = '0;
  logic            load = 1'b0;
  logic [BITS-1:0] period = '0;
  logic            period_load = 1'b0;
  logic            signal;
  logic            busy;
  logic            error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frequency_generator #(.UPDATE_PERIOD(1200), .BITS(BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .tens        (tens),
    .units       (units),
    .load        (load),
    .period      (period),
    .period_load (period_load),
    .signal      (signal),
    .busy        (busy),
    .error       (error)
  );

  // model: toggles after k RUN steps = floor(k*2n/P), from a base level
  int m_p, m_n, m_cd, m_k;
  bit m_run, m_sig, m_busy, m_err, m_base;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int toggles(int k);
    if (m_p == 0) return k;
    return (k * 2 * m_n) / m_p;
  endfunction

  task automatic m_reset();
    m_p = 1200; m_n = 0; m_cd = 0; m_k = 0;
    m_run = 0; m_sig = 0; m_busy = 0; m_err = 0; m_base = 0;
  endtask

  task automatic m_step(input bit ld, input int t, input int u,
                        input bit pl, input int per);
    if (ld) begin
      m_sig = 0; m_run = 0; m_cd = 0;
      if (t > 9 || u > 9) begin
        m_err = 1; m_busy = 0;
      end else begin
        m_err = 0; m_busy = 1; m_n = 10 * t + u; m_cd = t + 2;
      end
    end else if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        if (2 * m_n > m_p) begin
          m_err = 1; m_busy = 0;
        end else begin
          m_run = 1; m_k = 0; m_base = 0;
        end
      end
    end else if (m_run) begin
      if (pl) begin
        m_base = m_sig; m_k = 0;
      end else begin
        m_k++;
        m_sig = m_base ^ toggles(m_k)[0];
      end
    end
    if (pl) m_p = per;
  endtask

  task automatic cyc(input bit ld, input int t, input int u,
                     input bit pl, input int per);
    load = ld;
    tens = t[3:0];
    units = u[3:0];
    period_load = pl;
    period = per[BITS-1:0];
    @(posedge clk);
    m_step(ld, t, u, pl, per);
    #1;
    load = 1'b0;
    period_load = 1'b0;
    chk("signal", 32'(signal), 32'(m_sig));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("error", 32'(error), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic count_rises(input int n, output int rises,
                             output int wmin, output int wmax);
    bit prev;
    bit first;
    int w;
    prev = signal; first = 1; w = 1;
    rises = 0; wmin = 1 << 30; wmax = 0;
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (signal == prev) begin
        w++;
      end else begin
        if (!first) begin
          if (w < wmin) wmin = w;
          if (w > wmax) wmax = w;
        end
        first = 0;
        w = 1;
        if (signal) rises++;
      end
      prev = signal;
    end
  endtask

  int rises, wmin, wmax;

  initial begin
    m_reset();
    #23;
    chk("rst_signal", 32'(signal), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    @(negedge clk);
    reset = 1'b0;

    // 42 edges in 1200 clocks, levels 14 or 15 wide
    cyc(1, 4, 2, 0, 0);
    idle(5);
    count_rises(1200, rises, wmin, wmax);
    chk("rises_42", 32'(rises), 42);
    chk("wmin_14", 32'(wmin), 14);
    chk("wmax_15", 32'(wmax), 15);

    // asynchronous reset mid-cycle while running
    idle(7);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_signal", 32'(signal), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_error", 32'(error), 0);
    #1 reset = 1'b0;
    m_reset();

    // CHECK failure and recovery at a short period
    cyc(0, 0, 0, 1, 100);
    cyc(1, 9, 9, 0, 0);
    idle(11);
    chk("chk_fail_err", 32'(error), 1);
    cyc(1, 0, 5, 0, 0);
    idle(2);
    count_rises(100, rises, wmin, wmax);
    chk("rises_5", 32'(rises), 5);

    // invalid digits, then n=0
    cyc(1, 0, 10, 0, 0);
    chk("bad_digit_err", 32'(error), 1);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    count_rises(200, rises, wmin, wmax);
    chk("rises_0", 32'(rises), 0);

    // period change mid-run, then reload mid-run
    cyc(0, 0, 0, 1, 1200);
    cyc(1, 4, 2, 0, 0);
    idle(305);
    cyc(0, 0, 0, 1, 600);
    count_rises(600, rises, wmin, wmax);
    chk("rises_42_600", 32'(rises), 42);
    cyc(1, 1, 7, 0, 0);
    idle(2);
    count_rises(600, rises, wmin, wmax);
    chk("rises_17_600", 32'(rises), 17);

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)
        cyc(1, $urandom_range(0, 10), $urandom_range(0, 10), 0, 0);
      else if (r == 2)
        cyc(0, 0, 0, 1, $urandom_range(200, 1500));
      else if (r == 3)
        cyc(1, $urandom_range(0, 9), $urandom_range(0, 9), 1,
            $urandom_range(200, 1500));
      idle($urandom_range(1, 150));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
